// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package arm_mem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    localparam int          SRAM_AW           = 18;
    localparam int          SRAM_DW           = 16;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// SRAM bus between the memory-stage controller and the off-chip SRAM / DQ pad buffer.
interface mem_stage_sram_ctrl_if;
    import arm_mem_pkg::*;

    logic [SRAM_AW-1:0] sram_addr;
    logic [SRAM_DW-1:0] sram_dq_out;
    logic               sram_dq_oe;
    logic [SRAM_DW-1:0] sram_dq_in;
    logic               sram_we_n;

    modport master (
        output sram_addr,
        output sram_dq_out,
        output sram_dq_oe,
        output sram_we_n,
        input  sram_dq_in
    );

    modport slave (
        input  sram_addr,
        input  sram_dq_out,
        input  sram_dq_oe,
        input  sram_we_n,
        output sram_dq_in
    );
endinterface

// File: rtl/sram_wait_counter.sv
// Counts the cycles a half-access is held on the SRAM bus; last marks the final one.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] count,
    output logic       last
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= 3'd0;
        end else if (clr) begin
            count <= 3'd0;
        end else if (en) begin
            count <= count + 3'd1;
        end
    end

    assign last = (count == 3'(WAIT_CYCLES - 1));
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: each 32-bit load/store becomes two 16-bit SRAM accesses
// while ready is held low to freeze the pipeline.
module mem_stage_sram_ctrl
    import arm_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           ALU_res,
    input  logic [31:0]           Val_Rm,
    input  logic                  Mem_R_EN,
    input  logic                  Mem_W_EN,
    output logic                  ready,
    output logic [31:0]           read_data,
    mem_stage_sram_ctrl_if.master sram,
    output mem_state_t            dbg_state
);
    mem_state_t         state, next_state;
    logic               req, wr_q, op_wr;
    logic               cnt_clr, cnt_en, cnt_last;
    logic [2:0]         cnt;
    logic [31:0]        offs;
    logic [16:0]        word;
    logic [SRAM_AW-1:0] addr_d;
    logic [SRAM_DW-1:0] dq_d;
    logic               oe_d, we_n_d;
    logic               unused_bits;

    assign req         = Mem_R_EN | Mem_W_EN;
    assign offs        = ALU_res - BASE_ADDR;
    assign word        = offs[18:2];
    assign unused_bits = ^{offs[31:19], offs[1:0], cnt};
    assign dbg_state   = state;

    // ready is an advance/stall flag, not a handshake: low freezes every pipeline
    // register and the PC; an idle request lowers it combinationally in the same cycle.
    assign ready = (state == IDLE) ? !req : (state == DONE);

    // Write-vs-read must be known on the accepting edge, before wr_q is loaded.
    assign op_wr = (state == IDLE) ? Mem_W_EN : wr_q;

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt),
        .last  (cnt_last)
    );

    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: if (req) begin
                next_state = LO;
                cnt_clr    = 1'b1;
            end
            LO: if (cnt_last) begin
                next_state = HI;
                cnt_clr    = 1'b1;
            end else begin
                cnt_en = 1'b1;
            end
            HI: if (cnt_last) begin
                next_state = DONE;
                cnt_clr    = 1'b1;
            end else begin
                cnt_en = 1'b1;
            end
            DONE: begin
                next_state = IDLE;
                cnt_clr    = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // Bus values for the coming cycle, registered so they change only at boundaries.
    always_comb begin
        addr_d = '0;
        dq_d   = '0;
        oe_d   = 1'b0;
        we_n_d = 1'b1;
        if (next_state == LO || next_state == HI) begin
            addr_d = {word, (next_state == HI)};
            if (op_wr) begin
                oe_d   = 1'b1;
                we_n_d = 1'b0;
                dq_d   = (next_state == HI) ? Val_Rm[31:16] : Val_Rm[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            wr_q             <= 1'b0;
            read_data        <= '0;
            sram.sram_addr   <= '0;
            sram.sram_dq_out <= '0;
            sram.sram_dq_oe  <= 1'b0;
            sram.sram_we_n   <= 1'b1;
        end else begin
            state <= next_state;
            if (state == IDLE && req) begin
                wr_q <= Mem_W_EN;
            end
            if (!wr_q && cnt_last) begin
                if (state == LO) read_data[15:0]  <= sram.sram_dq_in;
                if (state == HI) read_data[31:16] <= sram.sram_dq_in;
            end
            sram.sram_addr   <= addr_d;
            sram.sram_dq_out <= dq_d;
            sram.sram_dq_oe  <= oe_d;
            sram.sram_we_n   <= we_n_d;
        end
    end
endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory-stage controller of the 5-stage ARM pipeline, directly downstream of the EXE/MEM pipeline register. It consumes the registered ALU result (byte address), Val_Rm (store data), Mem_R_EN and Mem_W_EN. It performs each 32-bit load or store as two 16-bit accesses to an off-chip SRAM, and holds `ready` low to freeze the whole pipeline until the access completes. Load data goes to the MEM/WB register.

## Interface
Parameters:
- `WAIT_CYCLES`, 2: cycles each 16-bit half-access is held on the SRAM bus (legal range 1..7).
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `ALU_res` in 32: byte address of the access.
- `Val_Rm` in 32: store data.
- `Mem_R_EN` in 1: load request.
- `Mem_W_EN` in 1: store request.
- `ready` out 1: 1 means the pipeline may advance; 0 freezes all pipeline registers and the PC.
- `read_data` out 32: last completed load word.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_out` out 16: write data to the SRAM.
- `sram_dq_oe` out 1: drive enable for the top-level tri-state DQ buffer.
- `sram_dq_in` in 16: read data from the SRAM.
- `sram_we_n` out 1: SRAM write strobe, active-low.

## Operation
- Request: `req = Mem_R_EN | Mem_W_EN`. If both are high, treat the access as a write. Upstream must not produce this case; the bench checks write priority anyway.
- Address mapping:
  - `offs = ALU_res - BASE_ADDR`, 32-bit wrap-around subtraction.
  - `word = offs[18:2]`. Bits [1:0] are ignored, so unaligned accesses are word-aligned. Upper bits are discarded, so the address space wraps modulo 128K words.
  - Low half: `sram_addr = {word,1'b0}`, carrying bits [15:0].
  - High half: `sram_addr = {word,1'b1}`, carrying bits [31:16].
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if `req`, go to LO and load the wait counter to 0. Otherwise stay.
  - LO: increment the counter. When the counter reaches WAIT_CYCLES-1, go to HI and clear the counter.
  - HI: same rule as LO; exit goes to DONE.
  - DONE: go to IDLE unconditionally.
- Read/write snapshot: captured in IDLE on request acceptance. The inputs stay stable anyway because the pipeline is frozen.
- `ready`:
  - IDLE: `!req`.
  - LO and HI: 0.
  - DONE: 1.
  - Consequence: a new request in the IDLE cycle immediately after DONE starts a fresh access, which is back-to-back support.
- Write in LO/HI:
  - `sram_we_n = 0` and `sram_dq_oe = 1`.
  - `sram_dq_out = Val_Rm[15:0]` in LO, `Val_Rm[31:16]` in HI.
- Read in LO/HI:
  - `sram_we_n = 1` and `sram_dq_oe = 0`.
  - On the last cycle of LO, capture `sram_dq_in` into `read_data[15:0]`.
  - On the last cycle of HI, capture it into `read_data[31:16]`.
- Outside LO/HI: `sram_we_n = 1`, `sram_dq_oe = 0`, `sram_addr = 0`, `sram_dq_out = 0`.
- `read_data` holds its value until the next load overwrites it. Stores never modify it.

## Timing
- Reset values: state IDLE, counter 0, `read_data` 0, `sram_we_n` 1, `sram_dq_oe` 0, `sram_addr` 0, `sram_dq_out` 0. `ready` then follows `!req`.
- Latency with request first seen in cycle 0:
  - LO occupies cycles 1..W, where W = WAIT_CYCLES.
  - HI occupies cycles W+1..2W.
  - DONE is cycle 2W+1.
  - `ready` is low for cycles 0..2W and high in 2W+1. With W = 2 the stall is 5 cycles.
- Load data is valid in `read_data` in the DONE cycle, so the MEM/WB register samples it at the end of DONE.
- SRAM outputs are registered.
  - Address, data and strobe change only at state or counter boundaries.
  - `sram_addr` and `sram_dq_out` are stable for the full half-access window.
- Reset asserted mid-access: next edge goes to IDLE and strobes are released. The SRAM may hold a partially written word; no completion is guaranteed.
- A request dropped mid-access (illegal while frozen) is ignored; the access finishes.

## Structure
- Shared package `arm_mem_pkg` holds:
  - the state enum (IDLE, LO, HI, DONE, 2-bit);
  - `SRAM_AW = 18` and `SRAM_DW = 16`;
  - the default `BASE_ADDR`.
- Sub-module `sram_wait_counter`: 3-bit counter with clear and enable, and a `last` flag equal to `count == WAIT_CYCLES-1`. It is instantiated once. Everything else stays in a single module.

## Test plan
- Reset: hold `rst = 0` for 3 cycles with `Mem_R_EN = 1` → `read_data = 0`, `sram_we_n = 1`, `sram_dq_oe = 0`, FSM in IDLE. After release with no request → `ready = 1`.
- Store: `ALU_res = 1032`, `Val_Rm = 0xDEADBEEF`, W = 2 →
  - `sram_addr = 4`, dq `0xBEEF` for 2 cycles with `we_n = 0`;
  - then `sram_addr = 5`, dq `0xDEAD` for 2 cycles;
  - `ready` low for 5 cycles, high on the 6th.
- Load: SRAM model preloaded from the store above, `Mem_R_EN` at `ALU_res = 1033` (unaligned) → `read_data = 0xDEADBEEF` in the DONE cycle, `sram_dq_oe = 0` throughout.
- Back-to-back and WAIT_CYCLES = 1: store to 1024, then immediately a load from 1024 in the cycle after DONE → each access stalls 3 cycles with no IDLE gap; the load returns the stored word.
- Boundary: `ALU_res = 1020` (wraps to word 0x1FFFF) → `sram_addr = 0x3FFFE` then `0x3FFFF`. Both enables high → access performed as a write.
- Reset mid-access: assert `rst = 0` during HI of a load → next cycle IDLE, `read_data = 0`. A following load completes normally.
